// File: rtl/i2c_scl_gen_pkg.sv
// Shared definitions for the I2C SCL burst generator: FSM states and default widths.
package i2c_scl_gen_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOW,
      S_HIGH_WAIT,
      S_HIGH
   } scl_state_t;

   localparam int unsigned DEF_DIV_W       = 10;
   localparam int unsigned DEF_CNT_W       = 4;
   localparam int unsigned DEF_STRETCH_MAX = 4095;
   localparam int unsigned DEF_STRETCH_W   = 12;
   localparam int unsigned MIN_HALF        = 2;

endpackage

// File: rtl/i2c_scl_gen_sync.sv
// Two-flop synchroniser for open-drain pad inputs; resets to the released (high) level.
module i2c_sync
   import i2c_scl_gen_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_meta <= 1'b1;
         r_sync <= 1'b1;
      end else begin
         r_meta <= d;
         r_sync <= r_meta;
      end
   end

   assign q = r_sync;

endmodule

// File: rtl/i2c_scl_gen.sv
// SCL burst engine: emits n_cycles SCL pulses at a programmable half-period,
// waits out slave clock stretching with a timeout, and emits phase ticks for the shifter.
module i2c_scl_gen
   import i2c_scl_gen_pkg::*;
#(
   parameter int unsigned DIV_W       = DEF_DIV_W,
   parameter int unsigned CNT_W       = DEF_CNT_W,
   parameter int unsigned STRETCH_MAX = DEF_STRETCH_MAX,
   parameter int unsigned STRETCH_W   = DEF_STRETCH_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [DIV_W-1:0] half_period,
   input  logic [CNT_W-1:0] n_cycles,
   input  logic             scl_in,
   output logic             scl_oe,
   output logic             tick_drive,
   output logic             tick_sample,
   output logic             tick_rise,
   output logic             tick_fall,
   output logic             busy,
   output logic             done,
   output logic             stretch_timeout
);

   scl_state_t r_state, w_state_nx;
   logic [DIV_W-1:0]     r_half, w_half_nx, r_ctr, w_ctr_nx;
   logic [CNT_W-1:0]     r_rem, w_rem_nx;
   logic [STRETCH_W-1:0] r_sctr, w_sctr_nx;
   logic r_zero_pend, w_zero_pend_nx;
   logic r_scl_oe, r_drive, r_sample, r_rise, r_fall, r_busy, r_done, r_to;
   logic w_scl_oe_nx, w_drive_nx, w_sample_nx, w_rise_nx, w_fall_nx, w_done_nx, w_to_nx;
   logic w_scl_s;
   logic [DIV_W-1:0] w_half_in, w_half_mid, w_half_last;

   i2c_sync u_scl_sync (
      .clk (clk),
      .rst (rst),
      .d   (scl_in),
      .q   (w_scl_s)
   );

   assign w_half_in   = (half_period < DIV_W'(MIN_HALF)) ? DIV_W'(MIN_HALF) : half_period;
   assign w_half_mid  = r_half >> 1;
   assign w_half_last = r_half - DIV_W'(1);

   always_comb begin
      w_state_nx     = r_state;
      w_half_nx      = r_half;
      w_ctr_nx       = r_ctr;
      w_rem_nx       = r_rem;
      w_sctr_nx      = r_sctr;
      w_zero_pend_nx = 1'b0;
      w_scl_oe_nx    = r_scl_oe;
      w_drive_nx     = 1'b0;
      w_sample_nx    = 1'b0;
      w_rise_nx      = 1'b0;
      w_fall_nx      = 1'b0;
      // an empty burst reports done one cycle after acceptance, like a real burst's edge timing
      w_done_nx      = r_zero_pend;
      w_to_nx        = 1'b0;

      case (r_state)
         S_IDLE: begin
            w_scl_oe_nx = 1'b0;
            if (start) begin
               if (n_cycles != '0) begin
                  w_state_nx  = S_LOW;
                  w_half_nx   = w_half_in;
                  w_rem_nx    = n_cycles;
                  w_ctr_nx    = '0;
                  w_scl_oe_nx = 1'b1;
               end else begin
                  w_zero_pend_nx = 1'b1;
               end
            end
         end
         S_LOW: begin
            w_drive_nx = (r_ctr == w_half_mid);
            if (r_ctr == w_half_last) begin
               w_state_nx  = S_HIGH_WAIT;
               w_scl_oe_nx = 1'b0;
               w_ctr_nx    = '0;
               w_sctr_nx   = STRETCH_W'(1);
            end else begin
               w_ctr_nx = r_ctr + DIV_W'(1);
            end
         end
         S_HIGH_WAIT: begin
            if (r_sctr == STRETCH_W'(STRETCH_MAX)) begin
               w_state_nx = S_IDLE;
               w_to_nx    = 1'b1;
               w_sctr_nx  = '0;
            end else if (w_scl_s) begin
               w_state_nx = S_HIGH;
               w_rise_nx  = 1'b1;
               w_ctr_nx   = '0;
            end else begin
               w_sctr_nx = r_sctr + STRETCH_W'(1);
            end
         end
         S_HIGH: begin
            w_sample_nx = (r_ctr == w_half_mid);
            if (r_ctr == w_half_last) begin
               w_ctr_nx = '0;
               if (r_rem == CNT_W'(1)) begin
                  w_state_nx = S_IDLE;
                  w_done_nx  = 1'b1;
                  w_rem_nx   = '0;
               end else begin
                  w_state_nx  = S_LOW;
                  w_rem_nx    = r_rem - CNT_W'(1);
                  w_fall_nx   = 1'b1;
                  w_scl_oe_nx = 1'b1;
               end
            end else begin
               w_ctr_nx = r_ctr + DIV_W'(1);
            end
         end
         default: w_state_nx = S_IDLE;
      endcase

      if (abort) begin
         w_state_nx     = S_IDLE;
         w_ctr_nx       = '0;
         w_sctr_nx      = '0;
         w_zero_pend_nx = 1'b0;
         w_scl_oe_nx    = 1'b0;
         w_drive_nx     = 1'b0;
         w_sample_nx    = 1'b0;
         w_rise_nx      = 1'b0;
         w_fall_nx      = 1'b0;
         w_done_nx      = 1'b0;
         w_to_nx        = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_half      <= '0;
         r_ctr       <= '0;
         r_rem       <= '0;
         r_sctr      <= '0;
         r_zero_pend <= 1'b0;
         r_scl_oe    <= 1'b0;
         r_drive     <= 1'b0;
         r_sample    <= 1'b0;
         r_rise      <= 1'b0;
         r_fall      <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_to        <= 1'b0;
      end else begin
         r_state     <= w_state_nx;
         r_half      <= w_half_nx;
         r_ctr       <= w_ctr_nx;
         r_rem       <= w_rem_nx;
         r_sctr      <= w_sctr_nx;
         r_zero_pend <= w_zero_pend_nx;
         r_scl_oe    <= w_scl_oe_nx;
         r_drive     <= w_drive_nx;
         r_sample    <= w_sample_nx;
         r_rise      <= w_rise_nx;
         r_fall      <= w_fall_nx;
         r_busy      <= (w_state_nx != S_IDLE);
         r_done      <= w_done_nx;
         r_to        <= w_to_nx;
      end
   end

   assign scl_oe          = r_scl_oe;
   assign tick_drive      = r_drive;
   assign tick_sample     = r_sample;
   assign tick_rise       = r_rise;
   assign tick_fall       = r_fall;
   assign busy            = r_busy;
   assign done            = r_done;
   assign stretch_timeout = r_to;

endmodule

// File: tb/tb_i2c_scl_gen.sv
// Directed bench for i2c_scl_gen with an open-drain SCL model and a slave that can hold SCL low.
module tb_i2c_scl_gen;

   logic       clk = 1'b0;
   logic       rst, start, abort;
   logic [9:0] half;
   logic [3:0] ncyc;
   logic       hold_a, hold_b;

   logic a_scl_in, a_scl_oe, a_drive, a_sample, a_rise, a_fall, a_busy, a_done, a_to;
   logic b_scl_in, b_scl_oe, b_drive, b_sample, b_rise, b_fall, b_busy, b_done, b_to;

   int n_pass = 0, n_total = 0;
   int n_drive, n_sample, n_rise, n_fall, n_done, n_to, n_bdone, n_bto;

   assign a_scl_in = ~a_scl_oe & ~hold_a;
   assign b_scl_in = ~b_scl_oe & ~hold_b;

   always #5 clk = ~clk;

   i2c_scl_gen u_a (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .half_period(half), .n_cycles(ncyc), .scl_in(a_scl_in),
      .scl_oe(a_scl_oe), .tick_drive(a_drive), .tick_sample(a_sample),
      .tick_rise(a_rise), .tick_fall(a_fall), .busy(a_busy), .done(a_done),
      .stretch_timeout(a_to)
   );

   i2c_scl_gen #(.STRETCH_MAX(16)) u_b (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .half_period(half), .n_cycles(ncyc), .scl_in(b_scl_in),
      .scl_oe(b_scl_oe), .tick_drive(b_drive), .tick_sample(b_sample),
      .tick_rise(b_rise), .tick_fall(b_fall), .busy(b_busy), .done(b_done),
      .stretch_timeout(b_to)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic clear();
      n_drive = 0; n_sample = 0; n_rise = 0; n_fall = 0;
      n_done = 0; n_to = 0; n_bdone = 0; n_bto = 0;
   endtask

   // advance one clock and sample on the falling edge
   task automatic step();
      @(negedge clk);
      if (a_drive)  n_drive++;
      if (a_sample) n_sample++;
      if (a_rise)   n_rise++;
      if (a_fall)   n_fall++;
      if (a_done)   n_done++;
      if (a_to)     n_to++;
      if (b_done)   n_bdone++;
      if (b_to)     n_bto++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int done_k, rise3_k, rel_k, to_k, falls;
      logic prev_oe;

      rst = 1'b1; start = 1'b0; abort = 1'b0; half = 10'd4; ncyc = 4'd2;
      hold_a = 1'b0; hold_b = 1'b0;
      clear();
      repeat (3) step();
      chk("reset_a", {a_scl_oe, a_drive, a_sample, a_rise, a_fall, a_busy, a_done, a_to}, 0);
      chk("reset_b", {b_scl_oe, b_drive, b_sample, b_rise, b_fall, b_busy, b_done, b_to}, 0);
      rst = 1'b0;
      step();

      // 1: H=4, N=2, ideal bus
      half = 10'd4; ncyc = 4'd2; start = 1'b1; clear();
      step();
      start = 1'b0;
      for (int k = 0; k <= 22; k++) begin
         if (k > 0) step();
         chk($sformatf("t1_oe_k%0d", k), a_scl_oe, (k < 4) || (k >= 11 && k < 15));
         chk($sformatf("t1_busy_k%0d", k), a_busy, k < 22);
         chk($sformatf("t1_done_k%0d", k), a_done, k == 22);
      end
      chk("t1_n_drive", n_drive, 2);
      chk("t1_n_sample", n_sample, 2);
      chk("t1_n_rise", n_rise, 2);
      chk("t1_n_fall", n_fall, 1);
      chk("t1_n_done", n_done, 1);
      repeat (3) step();

      // 2: H=8, N=9, slave stretches pulse 3 by 20 cycles
      half = 10'd8; ncyc = 4'd9; start = 1'b1; clear();
      step();
      start = 1'b0;
      done_k = -1; rise3_k = -1; rel_k = -1; falls = 0; prev_oe = 1'b1;
      for (int k = 0; k < 400 && done_k < 0; k++) begin
         if (k > 0) step();
         if (prev_oe && !a_scl_oe) begin
            falls++;
            if (falls == 3) begin hold_a = 1'b1; rel_k = k + 20; end
         end
         if (hold_a && k == rel_k) hold_a = 1'b0;
         if (a_rise && n_rise == 3) rise3_k = k;
         if (a_done) done_k = k;
         prev_oe = a_scl_oe;
      end
      hold_a = 1'b0;
      chk("t2_rise3_time", rise3_k, 69);
      chk("t2_done_time", done_k, 191);
      chk("t2_n_sample", n_sample, 9);
      chk("t2_n_fall", n_fall, 8);
      chk("t2_n_timeout", n_to, 0);
      repeat (3) step();

      // 3: permanent hold on the STRETCH_MAX=16 instance
      half = 10'd4; ncyc = 4'd2; hold_b = 1'b1; start = 1'b1; clear();
      step();
      start = 1'b0;
      to_k = -1;
      for (int k = 0; k <= 26; k++) begin
         if (k > 0) step();
         if (b_to) to_k = k;
      end
      chk("t3_timeout_time", to_k, 20);
      chk("t3_n_timeout", n_bto, 1);
      chk("t3_no_done", n_bdone, 0);
      chk("t3_busy", b_busy, 0);
      chk("t3_oe", b_scl_oe, 0);
      hold_b = 1'b0;
      repeat (3) step();

      // 4: zero-length burst
      ncyc = 4'd0; start = 1'b1; clear();
      step();
      start = 1'b0;
      for (int k = 0; k <= 4; k++) begin
         if (k > 0) step();
         chk($sformatf("t4_done_k%0d", k), a_done, k == 1);
         chk($sformatf("t4_busy_k%0d", k), a_busy, 0);
         chk($sformatf("t4_oe_k%0d", k), a_scl_oe, 0);
      end

      // 5: abort mid-LOW of pulse 2 with start asserted in the same cycle
      half = 10'd4; ncyc = 4'd2; start = 1'b1; clear();
      step();
      start = 1'b0;
      for (int k = 1; k <= 12; k++) step();
      chk("t5_pre_abort_oe", a_scl_oe, 1);
      abort = 1'b1; start = 1'b1;
      step();
      abort = 1'b0;
      chk("t5_abort_oe", a_scl_oe, 0);
      chk("t5_abort_busy", a_busy, 0);
      chk("t5_abort_done", a_done, 0);
      step();
      start = 1'b0;
      chk("t5_restart_busy", a_busy, 1);
      chk("t5_restart_oe", a_scl_oe, 1);
      done_k = -1;
      for (int k = 15; k <= 40; k++) begin
         step();
         if (a_done && done_k < 0) done_k = k;
      end
      chk("t5_restart_done_time", done_k, 36);
      chk("t5_n_done", n_done, 1);

      // 6: half_period=1 clamps to 2; reset mid-HIGH of pulse 2
      half = 10'd1; ncyc = 4'd2; start = 1'b1; clear();
      step();
      start = 1'b0;
      for (int k = 0; k <= 12; k++) begin
         if (k > 0) step();
         if (k <= 7) chk($sformatf("t6_oe_k%0d", k), a_scl_oe, (k < 2) || (k == 7));
      end
      chk("t6_busy_in_high", a_busy, 1);
      rst = 1'b1;
      step();
      chk("t6_rst_a", {a_scl_oe, a_drive, a_sample, a_rise, a_fall, a_busy, a_done, a_to}, 0);
      rst = 1'b0;
      repeat (4) step();
      chk("t6_post_rst_busy", a_busy, 0);
      chk("t6_post_rst_no_done", n_done, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
